// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-request and memory-response signals around mem_port_arbiter.
// Signal suffixes are written from the arbiter's point of view.
interface mem_port_arbiter_if #(
    parameter int unsigned AddrW = 64,
    parameter int unsigned DataW = 64
);
    localparam int unsigned MaskW = DataW / 8;

    logic             if_valid_i;
    logic             if_ready_o;
    logic [AddrW-1:0] if_addr_i;
    logic             if_rvalid_o;
    logic [DataW-1:0] if_rdata_o;

    logic             lsu_valid_i;
    logic             lsu_ready_o;
    logic             lsu_we_i;
    logic [AddrW-1:0] lsu_addr_i;
    logic [DataW-1:0] lsu_wdata_i;
    logic [MaskW-1:0] lsu_wmask_i;
    logic             lsu_rvalid_o;
    logic [DataW-1:0] lsu_rdata_o;

    logic             mem_valid_o;
    logic             mem_ready_i;
    logic             mem_we_o;
    logic [AddrW-1:0] mem_addr_o;
    logic [DataW-1:0] mem_wdata_o;
    logic [MaskW-1:0] mem_wmask_o;
    logic             mem_rvalid_i;
    logic [DataW-1:0] mem_rdata_i;

    modport slave (
        input  if_valid_i, if_addr_i,
        input  lsu_valid_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output if_ready_o, if_rvalid_o, if_rdata_o,
        output lsu_ready_o, lsu_rvalid_o, lsu_rdata_o,
        output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
    );

    modport master (
        output if_valid_i, if_addr_i,
        output lsu_valid_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  if_ready_o, if_rvalid_o, if_rdata_o,
        input  lsu_ready_o, lsu_rvalid_o, lsu_rdata_o,
        input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store.
// LSU has priority; a saturating starvation counter forces an IF win after StarveLimit LSU grants.
module mem_port_arbiter #(
    parameter int unsigned AddrW       = 64,
    parameter int unsigned DataW       = 64,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   bus
);
    localparam int unsigned MaskW = DataW / 8;
    localparam int unsigned StW   = $clog2(StarveLimit + 1);
    localparam logic [StW-1:0] StarveMax = StW'(StarveLimit);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]       r_state;
    logic             r_owner;
    logic [StW-1:0]   r_starve;
    logic             r_mem_valid;
    logic             r_mem_we;
    logic [AddrW-1:0] r_mem_addr;
    logic [DataW-1:0] r_mem_wdata;
    logic [MaskW-1:0] r_mem_wmask;
    logic             r_if_rvalid;
    logic [DataW-1:0] r_if_rdata;
    logic             r_lsu_rvalid;
    logic [DataW-1:0] r_lsu_rdata;

    logic             w_idle;
    logic             w_lsu_win;
    logic             w_if_win;
    logic [StW-1:0]   w_starve_lsu;

    always_comb begin
        // Readies are held low while rst_i is asserted.
        w_idle    = (r_state == StIdle) && !rst_i;
        w_lsu_win = w_idle && bus.lsu_valid_i && !(bus.if_valid_i && (r_starve == StarveMax));
        w_if_win  = w_idle && bus.if_valid_i && !w_lsu_win;
        if (!bus.if_valid_i) begin
            w_starve_lsu = '0;
        end else if (r_starve == StarveMax) begin
            w_starve_lsu = r_starve;
        end else begin
            w_starve_lsu = r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_owner      <= 1'b0;
            r_starve     <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_rdata  <= '0;
        end else begin
            r_if_rvalid  <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_lsu_win) begin
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= bus.lsu_we_i;
                        r_mem_addr  <= bus.lsu_addr_i;
                        r_mem_wdata <= bus.lsu_wdata_i;
                        r_mem_wmask <= bus.lsu_wmask_i;
                        r_owner     <= 1'b1;
                        r_starve    <= w_starve_lsu;
                        r_state     <= StReq;
                    end else if (w_if_win) begin
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= bus.if_addr_i;
                        r_mem_wdata <= '0;
                        r_mem_wmask <= '0;
                        r_owner     <= 1'b0;
                        r_starve    <= '0;
                        r_state     <= StReq;
                    end
                end
                StReq: begin
                    if (bus.mem_ready_i) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= StResp;
                    end
                end
                StResp: begin
                    if (bus.mem_rvalid_i) begin
                        if (r_owner) begin
                            r_lsu_rvalid <= 1'b1;
                            r_lsu_rdata  <= r_mem_we ? '0 : bus.mem_rdata_i;
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= bus.mem_rdata_i;
                        end
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_mem_valid <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign bus.if_ready_o   = w_if_win;
    assign bus.lsu_ready_o  = w_lsu_win;
    assign bus.if_rvalid_o  = r_if_rvalid;
    assign bus.if_rdata_o   = r_if_rdata;
    assign bus.lsu_rvalid_o = r_lsu_rvalid;
    assign bus.lsu_rdata_o  = r_lsu_rdata;
    assign bus.mem_valid_o  = r_mem_valid;
    assign bus.mem_we_o     = r_mem_we;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_wdata_o  = r_mem_wdata;
    assign bus.mem_wmask_o  = r_mem_wmask;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int unsigned AddrW       = 64;
    localparam int unsigned DataW       = 64;
    localparam int unsigned StarveLimit = 4;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: expected registered outputs plus transaction bookkeeping.
    logic        e_mvalid, e_mwe;
    logic [63:0] e_maddr, e_mwdata;
    logic [7:0]  e_mwmask;
    logic        e_ifrv, e_lsurv;
    logic [63:0] e_ifrd, e_lsurd;
    logic        m_wait_rsp, m_owner_lsu;
    int          m_starve;
    logic        hs_if, hs_lsu;
    int          grants[$];
    int          hs_cyc[$];
    int          ifrv_cyc[$];
    int          lsurv_cyc[$];

    mem_port_arbiter_if #(.AddrW(AddrW), .DataW(DataW)) bus ();

    mem_port_arbiter #(
        .AddrW      (AddrW),
        .DataW      (DataW),
        .StarveLimit(StarveLimit)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_clear();
        e_mvalid    = 1'b0;
        e_mwe       = 1'b0;
        e_maddr     = '0;
        e_mwdata    = '0;
        e_mwmask    = '0;
        e_ifrv      = 1'b0;
        e_lsurv     = 1'b0;
        e_ifrd      = '0;
        e_lsurd     = '0;
        m_wait_rsp  = 1'b0;
        m_owner_lsu = 1'b0;
        m_starve    = 0;
    endfunction

    // Called 1 time unit after a rising edge with inputs already driven; returns at the same point
    // of the following cycle.
    task automatic step();
        logic busy, e_lrdy, e_irdy;
        #1;
        busy   = e_mvalid || m_wait_rsp;
        e_lrdy = !rst && !busy && bus.lsu_valid_i
                 && !(bus.if_valid_i && (m_starve == int'(StarveLimit)));
        e_irdy = !rst && !busy && bus.if_valid_i && !e_lrdy;
        check_val("lsu_ready", 64'(bus.lsu_ready_o), 64'(e_lrdy));
        check_val("if_ready", 64'(bus.if_ready_o), 64'(e_irdy));
        check_val("mem_valid", 64'(bus.mem_valid_o), 64'(e_mvalid));
        if (e_mvalid) begin
            check_val("mem_we", 64'(bus.mem_we_o), 64'(e_mwe));
            check_val("mem_addr", bus.mem_addr_o, e_maddr);
            check_val("mem_wdata", bus.mem_wdata_o, e_mwdata);
            check_val("mem_wmask", 64'(bus.mem_wmask_o), 64'(e_mwmask));
        end
        check_val("if_rvalid", 64'(bus.if_rvalid_o), 64'(e_ifrv));
        check_val("lsu_rvalid", 64'(bus.lsu_rvalid_o), 64'(e_lsurv));
        if (e_ifrv) check_val("if_rdata", bus.if_rdata_o, e_ifrd);
        if (e_lsurv) check_val("lsu_rdata", bus.lsu_rdata_o, e_lsurd);
        if (bus.if_rvalid_o) ifrv_cyc.push_back(cyc);
        if (bus.lsu_rvalid_o) lsurv_cyc.push_back(cyc);

        e_ifrv  = 1'b0;
        e_lsurv = 1'b0;
        hs_if   = 1'b0;
        hs_lsu  = 1'b0;
        if (rst) begin
            model_clear();
        end else if (e_mvalid) begin
            if (bus.mem_ready_i) begin
                e_mvalid   = 1'b0;
                m_wait_rsp = 1'b1;
            end
        end else if (m_wait_rsp) begin
            if (bus.mem_rvalid_i) begin
                m_wait_rsp = 1'b0;
                if (m_owner_lsu) begin
                    e_lsurv = 1'b1;
                    e_lsurd = e_mwe ? 64'h0 : bus.mem_rdata_i;
                end else begin
                    e_ifrv = 1'b1;
                    e_ifrd = bus.mem_rdata_i;
                end
            end
        end else if (e_lrdy) begin
            e_mvalid    = 1'b1;
            e_mwe       = bus.lsu_we_i;
            e_maddr     = bus.lsu_addr_i;
            e_mwdata    = bus.lsu_wdata_i;
            e_mwmask    = bus.lsu_wmask_i;
            m_owner_lsu = 1'b1;
            m_starve    = bus.if_valid_i ? ((m_starve + 1 > int'(StarveLimit)) ? int'(StarveLimit)
                                                                             : m_starve + 1) : 0;
            hs_lsu      = 1'b1;
            grants.push_back(1);
            hs_cyc.push_back(cyc);
        end else if (e_irdy) begin
            e_mvalid    = 1'b1;
            e_mwe       = 1'b0;
            e_maddr     = bus.if_addr_i;
            e_mwdata    = '0;
            e_mwmask    = '0;
            m_owner_lsu = 1'b0;
            m_starve    = 0;
            hs_if       = 1'b1;
            grants.push_back(0);
            hs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.if_valid_i   = 1'b0;
        bus.if_addr_i    = '0;
        bus.lsu_valid_i  = 1'b0;
        bus.lsu_we_i     = 1'b0;
        bus.lsu_addr_i   = '0;
        bus.lsu_wdata_i  = '0;
        bus.lsu_wmask_i  = '0;
        bus.mem_ready_i  = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        grants.delete();
        hs_cyc.delete();
        ifrv_cyc.delete();
        lsurv_cyc.delete();
    endtask

    initial begin
        int exp_pat[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        int n_hs;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        // Both requesters valid during reset: no ready may appear.
        bus.if_valid_i  = 1'b1;
        bus.lsu_valid_i = 1'b1;
        do_reset();
        idle_inputs();

        // Single IF read with spurious rvalid held from Idle onwards.
        bus.if_valid_i   = 1'b1;
        bus.if_addr_i    = 64'h1000;
        bus.mem_ready_i  = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hDEAD;
        for (int i = 0; i < 7; i++) begin
            step();
            if (hs_if) bus.if_valid_i = 1'b0;
        end
        check_val("if_read_count", 64'(ifrv_cyc.size()), 64'd1);
        check_val("if_read_lsu_quiet", 64'(lsurv_cyc.size()), 64'd0);
        if (ifrv_cyc.size() == 1 && hs_cyc.size() == 1)
            check_val("if_read_latency", 64'(ifrv_cyc[0] - hs_cyc[0]), 64'd3);

        // LSU store held off by three stall cycles.
        idle_inputs();
        do_reset();
        bus.lsu_valid_i = 1'b1;
        bus.lsu_we_i    = 1'b1;
        bus.lsu_addr_i  = 64'h2008;
        bus.lsu_wdata_i = 64'h55;
        bus.lsu_wmask_i = 8'hFF;
        bus.mem_rdata_i = 64'hFACE;
        step();
        bus.lsu_valid_i = 1'b0;
        repeat (3) step();
        bus.mem_ready_i = 1'b1;
        step();
        bus.mem_ready_i  = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        step();
        bus.mem_rvalid_i = 1'b0;
        repeat (2) step();
        check_val("store_ack_count", 64'(lsurv_cyc.size()), 64'd1);

        // Contention with both requesters always valid.
        idle_inputs();
        do_reset();
        bus.if_valid_i   = 1'b1;
        bus.if_addr_i    = 64'h4000;
        bus.lsu_valid_i  = 1'b1;
        bus.lsu_addr_i   = 64'h8000;
        bus.mem_ready_i  = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.mem_rdata_i = {$urandom, $urandom};
            step();
            if (hs_lsu) bus.lsu_addr_i = bus.lsu_addr_i + 64'h8;
            if (hs_if) bus.if_addr_i = bus.if_addr_i + 64'h4;
        end
        check_val("contention_grants", 64'(grants.size() >= 11), 64'd1);
        if (grants.size() >= 11)
            for (int i = 0; i < 11; i++) check_val($sformatf("grant_%0d", i),
                                                   64'(grants[i]), 64'(exp_pat[i]));

        // Back-to-back LSU loads with an immediate memory.
        idle_inputs();
        do_reset();
        bus.lsu_valid_i  = 1'b1;
        bus.lsu_addr_i   = 64'h100;
        bus.mem_ready_i  = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'h1234_5678_9ABC_DEF0;
        n_hs = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (hs_lsu) begin
                n_hs++;
                bus.lsu_addr_i = 64'h108;
                if (n_hs == 2) bus.lsu_valid_i = 1'b0;
            end
        end
        check_val("b2b_count", 64'(hs_cyc.size()), 64'd2);
        if (hs_cyc.size() == 2 && lsurv_cyc.size() >= 1) begin
            check_val("b2b_spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
            check_val("b2b_overlap", 64'(lsurv_cyc[0]), 64'(hs_cyc[1]));
        end

        // Reset while waiting for the response, then a late response.
        idle_inputs();
        do_reset();
        bus.lsu_valid_i = 1'b1;
        bus.lsu_we_i    = 1'b1;
        bus.lsu_addr_i  = 64'h3000;
        bus.mem_ready_i = 1'b1;
        for (int i = 0; i < 20 && !m_wait_rsp; i++) begin
            step();
            if (hs_lsu) bus.lsu_valid_i = 1'b0;
        end
        check_val("reach_resp", 64'(m_wait_rsp), 64'd1);
        bus.if_valid_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.if_valid_i   = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        repeat (3) step();
        check_val("rst_resp_no_rvalid", 64'(ifrv_cyc.size() + lsurv_cyc.size()), 64'd0);
        bus.mem_rvalid_i = 1'b0;
        bus.if_valid_i   = 1'b1;
        bus.lsu_valid_i  = 1'b1;
        step();
        check_val("post_rst_lsu_wins", 64'(hs_lsu), 64'd1);

        // Randomized traffic with occasional resets.
        idle_inputs();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.mem_ready_i  = ($urandom_range(0, 3) != 0);
            bus.mem_rvalid_i = ($urandom_range(0, 2) == 0);
            bus.mem_rdata_i  = {$urandom, $urandom};
            if (hs_if) bus.if_valid_i = 1'b0;
            if (!bus.if_valid_i && $urandom_range(0, 2) != 0) begin
                bus.if_valid_i = 1'b1;
                bus.if_addr_i  = {$urandom, $urandom};
            end
            if (hs_lsu) bus.lsu_valid_i = 1'b0;
            if (!bus.lsu_valid_i && $urandom_range(0, 2) != 0) begin
                bus.lsu_valid_i = 1'b1;
                bus.lsu_we_i    = 1'($urandom_range(0, 1));
                bus.lsu_addr_i  = {$urandom, $urandom};
                bus.lsu_wdata_i = {$urandom, $urandom};
                bus.lsu_wmask_i = 8'($urandom);
            end
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
